param_data_memory: RTL and testbench
====================================

// Module: param_data_memory
// PURPOSE
//  Parametrised data memory for the 24-bit CPU datapath; successor to the fixed single-cycle data memory.
//  Adds a configurable wait-state count, per-byte write enables and a Ready/Done handshake.
//  Adds out-of-range and illegal-request error reporting.
//  Sits between the MEM stage and the memory array; the controller stalls on Ready=0 until Done.
// PARAMETERS
//  DATA_WIDTH  24   word width in bits; must be a multiple of 8
//  ADDR_WIDTH  24   word-address width
//  DEPTH       256  number of words; valid addresses are 0..DEPTH-1
//  LATENCY     2    wait cycles between acceptance and access; legal range 1..15
// PORTS
//  Clock       in   1             rising-edge clock
//  ResetN      in   1             synchronous, active-low reset
//  Address     in   ADDR_WIDTH    word address of request
//  WriteData   in   DATA_WIDTH    store data
//  ByteEnable  in   DATA_WIDTH/8  lane i covers bits [8i+7:8i]; used by writes only
//  MemWrite    in   1             write request
//  MemRead     in   1             read request
//  ReadData    out  DATA_WIDTH    read result; valid while Done=1, held until next read completes
//  Ready       out  1             1 = block can accept a request this cycle
//  Done        out  1             1-cycle completion pulse
//  Error       out  1             qualifies Done: request failed, memory untouched
// BEHAVIOUR
//  Reset (ResetN=0 at a rising edge):
//   - State goes to IDLE; Ready=1, Done=0, Error=0, ReadData=0.
//   - The internal wait counter clears.
//   - Memory contents are NOT cleared.
//   - Reset mid-operation aborts the request; a pending write never commits.
//  FSM states IDLE, WAIT, RESP:
//   - IDLE: Ready=1. At an edge with MemRead|MemWrite=1, latch Address, WriteData, ByteEnable and op.
//     Load the counter with LATENCY-1 and go to WAIT.
//   - WAIT: Ready=0; request inputs are ignored. The counter decrements each edge.
//     At the edge where the counter is 0, perform the access and go to RESP.
//   - RESP: Ready=0, Done=1 for exactly one cycle; next edge returns to IDLE.
//  Timing:
//   - Request accepted at edge E0; access occurs at edge E(LATENCY).
//   - Done is high in the cycle after E(LATENCY).
//   - Back-to-back issue interval is LATENCY+2 cycles.
//  Writes:
//   - For each lane with ByteEnable[i]=1, mem[Address][8i+7:8i] <= WriteData[8i+7:8i].
//   - Disabled lanes keep their old value.
//   - ByteEnable=0 completes normally with no change.
//   - Writes do not alter ReadData.
//  Reads:
//   - ReadData <= mem[Address] at the access edge; the full word is returned and ByteEnable is ignored.
//  Errors (reported in RESP with Done=1, Error=1; memory never modified):
//   - Address >= DEPTH (out of range): a read forces ReadData=0.
//   - MemRead=1 and MemWrite=1 together (illegal): no access; ReadData unchanged.
//  Inputs held high across RESP into IDLE are re-sampled as a new request.
//   - The CPU deasserts MemRead/MemWrite on Done to avoid a repeat.
//  All outputs are registered; there is no combinational path from inputs to outputs.
// TESTING (DATA_WIDTH=24, DEPTH=256, LATENCY=2 unless stated)
//  1. Reset: ResetN=0 for 2 edges -> Ready=1, Done=0, Error=0, ReadData=0.
//  2. Write Addr=16, WD=24'h000002, BE=3'b111, then read Addr=16
//     -> Done 3 cycles after each acceptance; ReadData=24'h000002; Error=0.
//  3. Preload Addr=10 with 24'hAABBCC; write WD=24'h112233, BE=3'b010; read
//     -> ReadData=24'hAA22CC.
//  4. Read Addr=300 -> Done=1, Error=1, ReadData=0.
//     MemRead=MemWrite=1 -> Error=1, no array change.
//  5. Write Addr=5, WD=24'h00FFFF; drop ResetN during WAIT; read Addr=5
//     -> Done 3 cycles after each acceptance; old contents returned.
//     Ready=0 throughout WAIT; a new request there is ignored.
//  6. LATENCY=1 and LATENCY=15: Done exactly LATENCY+1 cycles after acceptance
//     -> counter wrap and boundary values verified.

Source files
------------

// File: rtl/param_data_memory.sv
// Word-addressed data memory with a fixed number of wait states, per-byte write lanes,
// a Ready/Done handshake and error reporting for out-of-range or conflicting requests.
module param_data_memory #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 24,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2
) (
  input  logic                    Clock,
  input  logic                    ResetN,
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  input  logic [DATA_WIDTH/8-1:0] ByteEnable,
  input  logic                    MemWrite,
  input  logic                    MemRead,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    Ready,
  output logic                    Done,
  output logic                    Error
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NUM_LANES-1:0]    be_q, be_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    mem_we;
  logic                    in_range;
  logic [IDX_WIDTH-1:0]    idx;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
  assign idx      = addr_q[IDX_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          addr_d  = Address;
          wdata_d = WriteData;
          be_d    = ByteEnable;
          rd_d    = MemRead;
          wr_d    = MemWrite;
          cnt_d   = 4'(LATENCY - 1);
          ready_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          done_d  = 1'b1;
          // A conflicting request is rejected before the range check so ReadData is left alone.
          if (rd_q && wr_q) begin
            error_d = 1'b1;
          end else if (!in_range) begin
            error_d = 1'b1;
            if (rd_q) rdata_d = '0;
          end else if (rd_q) begin
            rdata_d = mem_q[idx];
          end else begin
            mem_we = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Request capture registers need no reset: they are only consumed after a fresh acceptance.
  always_ff @(posedge Clock) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    rd_q    <= rd_d;
    wr_q    <= wr_d;
  end

  always_ff @(posedge Clock) begin
    if (ResetN && mem_we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (be_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign ReadData = rdata_q;
  assign Ready    = ready_q;
  assign Done     = done_q;
  assign Error    = error_q;

endmodule

// File: tb/tb_param_data_memory.sv
// Directed plus randomized bench for param_data_memory, checked against an array-based
// reference model; extra instances cover the shortest and longest latency settings.
module tb_param_data_memory;

  localparam int DW    = 24;
  localparam int AW    = 24;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic          Clock = 1'b0;
  logic          ResetN;
  logic [AW-1:0] Address;
  logic [DW-1:0] WriteData;
  logic [2:0]    ByteEnable;
  logic          MemWrite, MemRead;
  logic [DW-1:0] ReadData;
  logic          Ready, Done, Error;

  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wd;
  logic [2:0]    l_be;
  logic          l_wr, l_rd;
  logic [DW-1:0] rd1, rd15;
  logic          rdy1, rdy15, dn1, dn15, er1, er15;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_rdata;

  always #5 Clock = ~Clock;

  param_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .Clock(Clock), .ResetN(ResetN), .Address(Address), .WriteData(WriteData),
    .ByteEnable(ByteEnable), .MemWrite(MemWrite), .MemRead(MemRead),
    .ReadData(ReadData), .Ready(Ready), .Done(Done), .Error(Error));

  param_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .Clock(Clock), .ResetN(ResetN), .Address(l_addr), .WriteData(l_wd),
    .ByteEnable(l_be), .MemWrite(l_wr), .MemRead(l_rd),
    .ReadData(rd1), .Ready(rdy1), .Done(dn1), .Error(er1));

  param_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(15)) dut_l15 (
    .Clock(Clock), .ResetN(ResetN), .Address(l_addr), .WriteData(l_wd),
    .ByteEnable(l_be), .MemWrite(l_wr), .MemRead(l_rd),
    .ReadData(rd15), .Ready(rdy15), .Done(dn15), .Error(er15));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: returns whether the request is an error and updates model state.
  function automatic logic ref_op(input logic rd, input logic wr, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wd, input logic [2:0] be);
    if (rd && wr) return 1'b1;
    if (int'(addr) >= DEPTH || addr >= AW'(DEPTH)) begin
      if (rd) ref_rdata = '0;
      return 1'b1;
    end
    if (rd) ref_rdata = ref_mem[addr];
    else begin
      for (int i = 0; i < 3; i++)
        if (be[i]) ref_mem[addr][8*i +: 8] = wd[8*i +: 8];
    end
    return 1'b0;
  endfunction

  task automatic clear_req();
    MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0; ByteEnable = '0;
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic do_op(input logic rd, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [2:0] be, input bit junk,
                       input string tag);
    int   edges;
    logic exp_err;
    check({tag, " ready_idle"}, 32'(Ready), 32'd1);
    MemRead = rd; MemWrite = wr; Address = addr; WriteData = wd; ByteEnable = be;
    @(posedge Clock); edges = 1;
    @(negedge Clock);
    clear_req();
    while (!Done && edges < 40) begin
      check({tag, " ready_wait"}, 32'(Ready), 32'd0);
      if (junk) begin
        MemWrite = 1'b1; MemRead = 1'($urandom);
        Address = AW'($urandom_range(0, 7)); WriteData = DW'($urandom); ByteEnable = 3'b111;
      end
      @(posedge Clock); edges++;
      @(negedge Clock);
    end
    clear_req();
    exp_err = ref_op(rd, wr, addr, wd, be);
    check({tag, " done"}, 32'(Done), 32'd1);
    check({tag, " latency"}, 32'(edges), 32'(LAT + 1));
    check({tag, " error"}, 32'(Error), 32'(exp_err));
    check({tag, " rdata"}, 32'(ReadData), 32'(ref_rdata));
    check({tag, " ready_resp"}, 32'(Ready), 32'd0);
    @(posedge Clock);
    @(negedge Clock);
    check({tag, " done_drop"}, 32'(Done), 32'd0);
  endtask

  task automatic lat_op(input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_data, input string tag);
    int e, e1, e15;
    logic [DW-1:0] d1, d15;
    check({tag, " ready1"}, 32'(rdy1), 32'd1);
    check({tag, " ready15"}, 32'(rdy15), 32'd1);
    l_rd = rd; l_wr = wr; l_addr = addr; l_wd = wd; l_be = 3'b111;
    @(posedge Clock); e = 1;
    @(negedge Clock);
    l_rd = 1'b0; l_wr = 1'b0;
    e1 = 0; e15 = 0; d1 = '0; d15 = '0;
    repeat (40) begin
      @(posedge Clock); e++;
      @(negedge Clock);
      if (dn1 && e1 == 0) begin e1 = e; d1 = rd1; end
      if (dn15 && e15 == 0) begin e15 = e; d15 = rd15; end
      if (e1 != 0 && e15 != 0) break;
    end
    check({tag, " lat1"}, 32'(e1), 32'd2);
    check({tag, " lat15"}, 32'(e15), 32'd16);
    if (rd) begin
      check({tag, " rdata1"}, 32'(d1), 32'(exp_data));
      check({tag, " rdata15"}, 32'(d15), 32'(exp_data));
    end
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    logic          err_dummy;
    logic          rd, wr;
    logic [AW-1:0] a;
    int            sel;

    ResetN = 1'b0;
    clear_req();
    l_rd = 1'b0; l_wr = 1'b0; l_addr = '0; l_wd = '0; l_be = '0;
    ref_rdata = '0;
    foreach (ref_mem[i]) ref_mem[i] = '0;

    // Reset state
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("reset ready", 32'(Ready), 32'd1);
    check("reset done", 32'(Done), 32'd0);
    check("reset error", 32'(Error), 32'd0);
    check("reset rdata", 32'(ReadData), 32'd0);
    ResetN = 1'b1;
    @(negedge Clock);

    // Basic write then read
    do_op(1'b0, 1'b1, 24'd16, 24'h000002, 3'b111, 1'b0, "t2 write");
    do_op(1'b1, 1'b0, 24'd16, 24'h0, 3'b000, 1'b0, "t2 read");
    check("t2 value", 32'(ReadData), 32'h000002);

    // Partial-lane write
    do_op(1'b0, 1'b1, 24'd10, 24'hAABBCC, 3'b111, 1'b0, "t3 preload");
    do_op(1'b0, 1'b1, 24'd10, 24'h112233, 3'b010, 1'b0, "t3 lane");
    do_op(1'b1, 1'b0, 24'd10, 24'h0, 3'b111, 1'b0, "t3 read");
    check("t3 value", 32'(ReadData), 32'hAA22CC);
    do_op(1'b0, 1'b1, 24'd10, 24'hFFFFFF, 3'b000, 1'b0, "t3 be0");

    // Error cases
    do_op(1'b1, 1'b0, 24'd300, 24'h0, 3'b111, 1'b0, "t4 oor read");
    check("t4 oor zero", 32'(ReadData), 32'd0);
    do_op(1'b1, 1'b0, 24'd16, 24'h0, 3'b111, 1'b0, "t4 reload");
    do_op(1'b1, 1'b1, 24'd16, 24'h777777, 3'b111, 1'b0, "t4 illegal");
    do_op(1'b0, 1'b1, 24'd256, 24'h5A5A5A, 3'b111, 1'b0, "t4 oor write");
    do_op(1'b1, 1'b0, 24'd0, 24'h0, 3'b111, 1'b0, "t4 alias");
    do_op(1'b1, 1'b0, 24'd16, 24'h0, 3'b111, 1'b0, "t4 intact");

    // Reset during WAIT aborts a pending write
    do_op(1'b0, 1'b1, 24'd5, 24'h123456, 3'b111, 1'b0, "t5 preload");
    MemWrite = 1'b1; Address = 24'd5; WriteData = 24'h00FFFF; ByteEnable = 3'b111;
    @(posedge Clock);
    @(negedge Clock);
    clear_req();
    check("t5 ready_wait", 32'(Ready), 32'd0);
    ResetN = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    ResetN = 1'b1;
    ref_rdata = '0;
    check("t5 reset ready", 32'(Ready), 32'd1);
    check("t5 reset done", 32'(Done), 32'd0);
    check("t5 reset rdata", 32'(ReadData), 32'd0);
    do_op(1'b1, 1'b0, 24'd5, 24'h0, 3'b000, 1'b1, "t5 read");
    check("t5 old", 32'(ReadData), 32'h123456);

    // Randomized traffic over a small preloaded pool, with junk requests during WAIT
    for (int i = 0; i < 8; i++)
      do_op(1'b0, 1'b1, AW'(i), DW'($urandom), 3'b111, 1'b0, "init");
    do_op(1'b0, 1'b1, 24'd255, DW'($urandom), 3'b111, 1'b0, "init255");
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = AW'($urandom_range(0, 7));
      else if (sel == 7) a = 24'd255;
      else if (sel == 8) a = AW'($urandom_range(256, 300));
      else               a = AW'($urandom) | 24'h800000;
      sel = $urandom_range(0, 8);
      rd = (sel <= 3) || (sel == 8);
      wr = (sel >= 4);
      do_op(rd, wr, a, DW'($urandom), 3'($urandom), 1'($urandom), "rand");
    end

    // Latency boundaries
    err_dummy = 1'b0;
    lat_op(1'b0, 1'b1, 24'd20, 24'hC0FFEE, 24'h0, "t6 write");
    lat_op(1'b1, 1'b0, 24'd20, 24'h0, 24'hC0FFEE, "t6 read");
    lat_op(1'b1, 1'b0, 24'd999, 24'h0, 24'h0, "t6 oor");
    check("t6 err1", 32'(er1), 32'(err_dummy));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
